// File: rtl/gpio_input_ctrl.sv
// gpio_input_ctrl
// Conditions raw GPIO pad inputs for the system clock domain. Each bit passes
// through a two-flop synchronizer and a per-bit debounce filter. Rising and
// falling edges of the filtered level are latched into sticky write-1-to-clear
// status flags. A single maskable interrupt line is produced from those flags.
module gpio_input_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4    // legal range 1..15 (4-bit counter)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] gpio_data_in,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpio_sync,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    // Terminal count of the debounce counter. A new level is accepted on the
    // cycle the counter sits at this value while the level still differs.
    localparam logic [3:0] CNT_MAX = 4'(DEB_CYCLES - 1);

    // Next debounce count for one bit: restart whenever the synchronized level
    // agrees with the accepted level or when the new level is being accepted,
    // otherwise advance. The count therefore never exceeds CNT_MAX.
    function automatic logic [3:0] deb_cnt_next(input logic       differ,
                                                input logic [3:0] cnt);
        if (!differ || (cnt == CNT_MAX)) begin
            return 4'd0;
        end
        return cnt + 4'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]      r_s1;
    logic [WIDTH-1:0]      r_s2;
    logic [WIDTH-1:0]      r_sync;
    logic [WIDTH-1:0][3:0] r_cnt;
    logic [WIDTH-1:0]      r_status;

    logic [WIDTH-1:0]      w_differ;
    logic [WIDTH-1:0]      w_accept;
    logic [WIDTH-1:0]      w_rise;
    logic [WIDTH-1:0]      w_fall;
    logic [WIDTH-1:0]      w_status_nxt;

    // Two-flop synchronizer; nothing may sit between the two stages.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= gpio_data_in;
            r_s2 <= r_s1;
        end
    end

    // Per-bit compare of the synchronized level against the accepted level.
    always_comb begin
        w_differ = '0;
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_differ[i] = r_s2[i] ^ r_sync[i];
            w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    // Debounce counters and accepted level. An accepted bit always differs
    // from its old value, so toggling it loads the synchronized level.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt  <= '0;
            r_sync <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= deb_cnt_next(w_differ[i], r_cnt[i]);
            end
            r_sync <= r_sync ^ w_accept;
        end
    end

    // ------------------------------------------------------------------
    // Edge events: only in the cycle the accepted level changes, and only
    // if the matching enable is set in that very cycle.
    // ------------------------------------------------------------------
    assign w_rise       = w_accept &  r_s2 & irq_rise_en;
    assign w_fall       = w_accept & ~r_s2 & irq_fall_en;

    // A set from a new event wins over a clear in the same cycle.
    assign w_status_nxt = (r_status & ~irq_clr) | w_rise | w_fall;

    // Sticky interrupt status flags.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_status <= '0;
        end else begin
            r_status <= w_status_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; the interrupt is combinational so mask changes act at once.
    // ------------------------------------------------------------------
    assign gpio_sync  = r_sync;
    assign irq_status = r_status;
    assign irq        = |(r_status & irq_en);

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Directed testbench for gpio_input_ctrl (default DEB_CYCLES=4 instance plus
// a DEB_CYCLES=1 instance sharing the same stimulus for the minimum latency).
module tb_gpio_input_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] gpio_data_in;
    logic [7:0] irq_rise_en;
    logic [7:0] irq_fall_en;
    logic [7:0] irq_en;
    logic [7:0] irq_clr;
    logic [7:0] gpio_sync;
    logic [7:0] irq_status;
    logic       irq;
    logic [7:0] gpio_sync1;
    logic [7:0] irq_status1;
    logic       irq1;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_input_ctrl #(.WIDTH(8), .DEB_CYCLES(4)) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .gpio_data_in (gpio_data_in),
        .irq_rise_en  (irq_rise_en),
        .irq_fall_en  (irq_fall_en),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .gpio_sync    (gpio_sync),
        .irq_status   (irq_status),
        .irq          (irq)
    );

    gpio_input_ctrl #(.WIDTH(8), .DEB_CYCLES(1)) u_dut1 (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .gpio_data_in (gpio_data_in),
        .irq_rise_en  (irq_rise_en),
        .irq_fall_en  (irq_fall_en),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .gpio_sync    (gpio_sync1),
        .irq_status   (irq_status1),
        .irq          (irq1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    initial begin
        sys_rst      = 1'b1;
        gpio_data_in = 8'hFF;
        irq_rise_en  = 8'h00;
        irq_fall_en  = 8'h00;
        irq_en       = 8'h00;
        irq_clr      = 8'h00;

        // 1. Reset held with all inputs high
        ticks(3);
        check("rst_sync",    32'(gpio_sync),   32'h00);
        check("rst_status",  32'(irq_status),  32'h00);
        check("rst_irq",     32'(irq),         32'h0);
        check("rst_sync_d1", 32'(gpio_sync1),  32'h00);
        gpio_data_in = 8'h00;
        sys_rst      = 1'b0;
        ticks(3);
        check("idle_sync",   32'(gpio_sync),   32'h00);

        // 2. Rising edge latency: s1 captures at edge k (e=0)
        irq_rise_en  = 8'h01;
        irq_en       = 8'h01;
        gpio_data_in = 8'h01;
        for (int e = 0; e <= 5; e++) begin
            tick();
            check($sformatf("lat_sync_e%0d", e),   32'(gpio_sync),  (e == 5) ? 32'h01 : 32'h00);
            check($sformatf("lat_status_e%0d", e), 32'(irq_status), (e == 5) ? 32'h01 : 32'h00);
            check($sformatf("lat_d1_e%0d", e),     32'(gpio_sync1), (e >= 2) ? 32'h01 : 32'h00);
        end
        check("lat_irq", 32'(irq), 32'h1);

        // 4. Write-1-to-clear, then clear colliding with a new event
        irq_clr = 8'h01;
        tick();
        irq_clr = 8'h00;
        check("w1c_status", 32'(irq_status), 32'h00);
        check("w1c_irq",    32'(irq),        32'h0);
        irq_fall_en  = 8'h01;
        gpio_data_in = 8'h00;
        ticks(5);                        // edges k..k+4
        check("coll_pre_sync", 32'(gpio_sync), 32'h01);
        irq_clr = 8'h01;
        tick();                          // edge k+5: fall accepted with clear
        irq_clr = 8'h00;
        check("coll_sync",   32'(gpio_sync),  32'h00);
        check("coll_status", 32'(irq_status), 32'h01);
        check("coll_irq",    32'(irq),        32'h1);
        irq_clr = 8'hFF;
        tick();
        irq_clr = 8'h00;
        check("coll_clr", 32'(irq_status), 32'h00);

        // 3. Glitch rejection with all edges enabled
        irq_rise_en  = 8'hFF;
        irq_fall_en  = 8'hFF;
        gpio_data_in = 8'h08;
        ticks(3);
        gpio_data_in = 8'h00;
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("glitch_sync_%0d", e),   32'(gpio_sync),  32'h00);
            check($sformatf("glitch_status_%0d", e), 32'(irq_status), 32'h00);
        end
        gpio_data_in = 8'h08;
        ticks(4);                        // edges k..k+3
        gpio_data_in = 8'h00;
        tick();                          // k+4
        check("pulse4_k4", 32'(gpio_sync), 32'h00);
        tick();                          // k+5
        check("pulse4_k5",     32'(gpio_sync),  32'h08);
        check("pulse4_status", 32'(irq_status), 32'h08);
        ticks(3);                        // k+8
        check("pulse4_k8", 32'(gpio_sync), 32'h08);
        tick();                          // k+9: 5 edges after falling capture
        check("pulse4_k9", 32'(gpio_sync), 32'h00);
        irq_clr = 8'hFF;
        tick();
        irq_clr = 8'h00;
        check("pulse4_clr", 32'(irq_status), 32'h00);

        // 5. Edge-type selection and masking
        irq_fall_en  = 8'h80;
        irq_rise_en  = 8'h00;
        irq_en       = 8'h00;
        gpio_data_in = 8'h80;
        ticks(7);
        check("sel_rise_sync",   32'(gpio_sync),  32'h80);
        check("sel_rise_status", 32'(irq_status), 32'h00);
        gpio_data_in = 8'h00;
        ticks(7);
        check("sel_fall_status", 32'(irq_status), 32'h80);
        check("sel_fall_irq",    32'(irq),        32'h0);
        irq_en = 8'h80;
        #1;
        check("sel_mask_irq", 32'(irq), 32'h1);

        // 6. Reset mid-debounce, also checks the asynchronous clear
        irq_rise_en  = 8'h04;
        gpio_data_in = 8'h04;
        ticks(4);                        // edges k..k+3: two counted cycles
        check("mid_sync", 32'(gpio_sync), 32'h00);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_status", 32'(irq_status), 32'h00);
        check("async_irq",    32'(irq),        32'h0);
        tick();
        sys_rst = 1'b0;
        ticks(5);                        // edges j..j+4 after release
        check("rst_restart_j4", 32'(gpio_sync), 32'h00);
        tick();                          // j+5
        check("rst_restart_j5", 32'(gpio_sync),  32'h04);
        check("rst_rise",       32'(irq_status), 32'h04);
        check("rst_rise_irq",   32'(irq),        32'h0);
        irq_en = 8'h04;
        #1;
        check("rst_rise_irq_en", 32'(irq), 32'h1);

        // Bit independence: several bits rise together
        irq_rise_en  = 8'hFF;
        irq_clr      = 8'hFF;
        tick();
        irq_clr      = 8'h00;
        gpio_data_in = 8'hF4;
        ticks(6);
        check("multi_sync",   32'(gpio_sync),  32'hF4);
        check("multi_status", 32'(irq_status), 32'hF0);
        irq_clr = 8'h30;
        tick();
        irq_clr = 8'h00;
        check("multi_clr", 32'(irq_status), 32'hC0);
        irq_en = 8'h40;
        #1;
        check("multi_irq", 32'(irq), 32'h1);
        irq_en = 8'h30;
        #1;
        check("multi_irq_masked", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
